// File: rtl/lmac_txfifo_gearbox.sv
// LMAC TX FIFO gearbox: pulls 64-bit FIFO words and emits 32-bit lanes (low half first), paced by link speed.
// Build macro LMAC_TXGB_IDLE_STATS_EN enables the saturating IDLE_TICK_CNT statistic (tied to 0 otherwise).
module lmac_txfifo_gearbox #(
    parameter int unsigned PACE_10G  = 1,
    parameter int unsigned PACE_5G   = 2,
    parameter int unsigned PACE_2P5G = 4,
    parameter int unsigned PACE_1G   = 10
) (
    input  logic        clk,
    input  logic        RESETN,
    input  logic        MODE_10G,
    input  logic        MODE_5G,
    input  logic        MODE_2P5G,
    input  logic        MODE_1G,
    input  logic        TXFIFO_RD_EMPTY,
    input  logic [63:0] TXFIFO_RD_OUTPUT,
    output logic        TXFIFO_RD_EN,
    output logic [31:0] TX_OUT_DATA,
    output logic        TX_OUT_VALID,
    output logic [1:0]  TX_BUF_LEVEL,
    output logic [15:0] IDLE_TICK_CNT
);
    typedef enum logic [2:0] {
        MODE_NONE  = 3'd0,
        MODE_S10G  = 3'd1,
        MODE_S5G   = 3'd2,
        MODE_S2P5G = 3'd3,
        MODE_S1G   = 3'd4
    } mode_e;

    localparam logic [3:0] LP_MAX_10G  = 4'(PACE_10G - 1);
    localparam logic [3:0] LP_MAX_5G   = 4'(PACE_5G - 1);
    localparam logic [3:0] LP_MAX_2P5G = 4'(PACE_2P5G - 1);
    localparam logic [3:0] LP_MAX_1G   = 4'(PACE_1G - 1);

    mode_e       w_mode;
    mode_e       r_mode;
    logic [3:0]  w_cnt_max;
    logic [3:0]  w_cnt;
    logic [3:0]  r_pace_cnt;
    logic        w_mode_act;
    logic        w_mode_chg;
    logic        w_tick;
    logic        w_emit;
    logic        w_retire;
    logic [1:0]  w_lvl_cmp;
    logic [2:0]  w_occ;
    logic        r_half;
    logic        r_inflight;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [1:0]  r_level;
    logic [63:0] r_cur;
    logic [63:0] r_nxt;

    always_comb begin
        w_mode    = MODE_NONE;
        w_cnt_max = 4'd0;
        if (MODE_10G) begin
            w_mode    = MODE_S10G;
            w_cnt_max = LP_MAX_10G;
        end else if (MODE_5G) begin
            w_mode    = MODE_S5G;
            w_cnt_max = LP_MAX_5G;
        end else if (MODE_2P5G) begin
            w_mode    = MODE_S2P5G;
            w_cnt_max = LP_MAX_2P5G;
        end else if (MODE_1G) begin
            w_mode    = MODE_S1G;
            w_cnt_max = LP_MAX_1G;
        end
    end

    assign w_mode_act = (w_mode != MODE_NONE);
    assign w_mode_chg = (w_mode != r_mode);
    // A mode switch restarts the pace count in the same cycle it is seen.
    assign w_cnt      = w_mode_chg ? 4'd0 : r_pace_cnt;
    assign w_tick     = w_mode_act && (w_cnt == w_cnt_max);
    assign w_emit     = w_tick && (r_level != 2'd0);
    assign w_retire   = w_emit && r_half;
    assign w_lvl_cmp  = r_level - {1'b0, w_retire};
    assign w_occ      = {1'b0, w_lvl_cmp} + {2'b00, r_inflight};

    assign TXFIFO_RD_EN  = RESETN && w_mode_act && !TXFIFO_RD_EMPTY && (w_occ < 3'd2);
    assign TX_OUT_DATA   = r_out_data;
    assign TX_OUT_VALID  = r_out_valid;
    assign TX_BUF_LEVEL  = r_level;

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_mode      <= MODE_NONE;
            r_pace_cnt  <= 4'd0;
            r_half      <= 1'b0;
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_level     <= 2'd0;
            r_cur       <= 64'd0;
            r_nxt       <= 64'd0;
        end else begin
            r_mode      <= w_mode;
            r_pace_cnt  <= (!w_mode_act || w_tick) ? 4'd0 : w_cnt + 4'd1;
            r_inflight  <= TXFIFO_RD_EN;
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_data <= r_half ? r_cur[63:32] : r_cur[31:0];
                r_half     <= ~r_half;
            end
            // Compact on retire first, then land the returning word in the first free slot.
            if (w_retire) begin
                r_cur <= r_nxt;
            end
            if (r_inflight) begin
                if (w_lvl_cmp == 2'd0) begin
                    r_cur <= TXFIFO_RD_OUTPUT;
                end else begin
                    r_nxt <= TXFIFO_RD_OUTPUT;
                end
            end
            r_level <= w_lvl_cmp + {1'b0, r_inflight};
        end
    end

`ifdef LMAC_TXGB_IDLE_STATS_EN
    logic [15:0] r_idle_cnt;

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_idle_cnt <= 16'd0;
        end else if (w_tick && (r_level == 2'd0) && (r_idle_cnt != 16'hFFFF)) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign IDLE_TICK_CNT = r_idle_cnt;
`else
    assign IDLE_TICK_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_lmac_txfifo_gearbox.sv
// Self-checking bench for lmac_txfifo_gearbox: FIFO model, lane recorder and per-scenario tasks.
// Expected lanes are derived from the pushed words (low half then high half) and the per-mode pace.
module tb_lmac_txfifo_gearbox;
    logic        clk;
    logic        RESETN;
    logic        MODE_10G;
    logic        MODE_5G;
    logic        MODE_2P5G;
    logic        MODE_1G;
    logic        fifo_empty;
    logic [63:0] fifo_rd_out;
    logic        TXFIFO_RD_EN;
    logic [31:0] TX_OUT_DATA;
    logic        TX_OUT_VALID;
    logic [1:0]  TX_BUF_LEVEL;
    logic [15:0] IDLE_TICK_CNT;

    int checks;
    int failures;
    int cyc;

    lmac_txfifo_gearbox dut (
        .clk              (clk),
        .RESETN           (RESETN),
        .MODE_10G         (MODE_10G),
        .MODE_5G          (MODE_5G),
        .MODE_2P5G        (MODE_2P5G),
        .MODE_1G          (MODE_1G),
        .TXFIFO_RD_EMPTY  (fifo_empty),
        .TXFIFO_RD_OUTPUT (fifo_rd_out),
        .TXFIFO_RD_EN     (TXFIFO_RD_EN),
        .TX_OUT_DATA      (TX_OUT_DATA),
        .TX_OUT_VALID     (TX_OUT_VALID),
        .TX_BUF_LEVEL     (TX_BUF_LEVEL),
        .IDLE_TICK_CNT    (IDLE_TICK_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: registered read data, flushed together with this block's reset.
    logic [63:0] fifo_mem [0:255];
    int unsigned fifo_wr_ptr = 0;
    int unsigned fifo_rd_ptr = 0;
    int          underrun_cnt = 0;
    logic [63:0] exp_words [$];

    assign fifo_empty = (fifo_rd_ptr == fifo_wr_ptr);

    always @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            fifo_rd_ptr <= fifo_wr_ptr;
        end else if (TXFIFO_RD_EN) begin
            if (fifo_rd_ptr == fifo_wr_ptr) begin
                underrun_cnt <= underrun_cnt + 1;
            end else begin
                fifo_rd_out <= fifo_mem[fifo_rd_ptr[7:0]];
                fifo_rd_ptr <= fifo_rd_ptr + 1;
            end
        end
    end

    // Recorder: lanes, read requests and buffer occupancy (level + word in flight).
    logic [31:0] obs_data [$];
    int          obs_cyc [$];
    int          rd_cnt = 0;
    int          rd_first = -1;
    int          max_occ = 0;
    int          prev_rd = 0;
    int          clr_req = 0;
    int          clr_seen = 0;

    always @(negedge clk) begin
        int occ;
        #2;
        if (clr_seen != clr_req) begin
            obs_data.delete();
            obs_cyc.delete();
            rd_cnt   = 0;
            rd_first = -1;
            max_occ  = 0;
            prev_rd  = 0;
            clr_seen = clr_req;
        end
        occ = int'(TX_BUF_LEVEL) + prev_rd;
        if (occ > max_occ) max_occ = occ;
        if (TX_OUT_VALID) begin
            obs_data.push_back(TX_OUT_DATA);
            obs_cyc.push_back(cyc);
        end
        if (TXFIFO_RD_EN) begin
            rd_cnt = rd_cnt + 1;
            if (rd_first < 0) rd_first = cyc;
        end
        prev_rd = (RESETN && TXFIFO_RD_EN) ? 1 : 0;
    end

    function automatic logic [31:0] lane_exp(input int i);
        logic [63:0] w;
        if (i / 2 >= exp_words.size()) return 32'hxxxxxxxx;
        w = exp_words[i / 2];
        return (i % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    function automatic logic [31:0] lane_obs(input int i);
        return (i < obs_data.size()) ? obs_data[i] : 32'hxxxxxxxx;
    endfunction

    function automatic int cyc_obs(input int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_modes(input logic [3:0] m);
        {MODE_10G, MODE_5G, MODE_2P5G, MODE_1G} = m;
    endtask

    task automatic do_reset;
        RESETN = 1'b0;
        set_modes(4'b0000);
        exp_words.delete();
        clr_req = clr_req + 1;
        step(2);
    endtask

    task automatic push_word(input logic [63:0] w);
        fifo_mem[fifo_wr_ptr[7:0]] = w;
        fifo_wr_ptr = fifo_wr_ptr + 1;
        exp_words.push_back(w);
    endtask

    task automatic wait_lanes(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            step(1);
            k++;
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic wait_valid_now(input int budget, output bit ok);
        int k = 0;
        while (!TX_OUT_VALID && k < budget) begin
            step(1);
            k++;
        end
        ok = TX_OUT_VALID;
    endtask

    task automatic test_reset;
        logic pre_valid;
        do_reset();
        checks += 5;
        if (TX_OUT_DATA !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", TX_OUT_DATA); end
        if (TX_OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", TX_OUT_VALID); end
        if (TX_BUF_LEVEL !== 2'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", TX_BUF_LEVEL); end
        if (TXFIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL rst_rden got=%b exp=0", TXFIFO_RD_EN); end
        if (IDLE_TICK_CNT !== 16'd0) begin failures++; $display("FAIL rst_idle got=%0d exp=0", IDLE_TICK_CNT); end
        RESETN = 1'b1;
        set_modes(4'b1000);
        step(10);
        checks += 2;
        if (rd_cnt !== 0) begin failures++; $display("FAIL empty_rden got=%0d exp=0", rd_cnt); end
        if (obs_data.size() !== 0) begin failures++; $display("FAIL empty_valid got=%0d lanes exp=0", obs_data.size()); end
        for (int k = 0; k < 6; k++) push_word({$urandom, $urandom});
        step(6);
        pre_valid = TX_OUT_VALID;
        checks++;
        if (pre_valid !== 1'b1) begin failures++; $display("FAIL midstream_valid got=%b exp=1", pre_valid); end
        #2;
        RESETN = 1'b0;
        #1;
        checks += 4;
        if (TX_OUT_DATA !== 32'd0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", TX_OUT_DATA); end
        if (TX_OUT_VALID !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", TX_OUT_VALID); end
        if (TX_BUF_LEVEL !== 2'd0) begin failures++; $display("FAIL async_rst_level got=%0d exp=0", TX_BUF_LEVEL); end
        if (TXFIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL async_rst_rden got=%b exp=0", TXFIFO_RD_EN); end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_stream_10g;
        bit ok;
        int nl;
        do_reset();
        RESETN = 1'b1;
        push_word(64'h1111_2222_3333_4444);
        push_word(64'h5555_6666_7777_8888);
        for (int k = 0; k < 6; k++) push_word({$urandom, $urandom});
        set_modes(4'b1000);
        nl = 2 * exp_words.size();
        wait_lanes(nl, 80, ok);
        step(5);
        checks += 2;
        if (!ok || obs_data.size() != nl) begin failures++; $display("FAIL s10g_count got=%0d exp=%0d", obs_data.size(), nl); end
        if (cyc_obs(0) - rd_first !== 3) begin failures++; $display("FAIL s10g_latency got=%0d exp=3", cyc_obs(0) - rd_first); end
        for (int i = 0; i < nl; i++) begin
            checks++;
            if (lane_obs(i) !== lane_exp(i)) begin failures++; $display("FAIL s10g_lane%0d got=%h exp=%h", i, lane_obs(i), lane_exp(i)); end
        end
        for (int i = 1; i < nl; i++) begin
            checks++;
            if (cyc_obs(i) - cyc_obs(i - 1) !== 1) begin failures++; $display("FAIL s10g_gap%0d got=%0d exp=1", i, cyc_obs(i) - cyc_obs(i - 1)); end
        end
        checks += 2;
        if (max_occ > 2) begin failures++; $display("FAIL s10g_occupancy got=%0d exp<=2", max_occ); end
        if (underrun_cnt !== 0) begin failures++; $display("FAIL s10g_underrun got=%0d exp=0", underrun_cnt); end
        $display("test_stream_10g lanes=%0d first_rd=%0d first_valid=%0d", obs_data.size(), rd_first, cyc_obs(0));
    endtask

    task automatic test_pacing;
        for (int m = 0; m < 4; m++) begin
            bit ok;
            int d;
            int n;
            logic [3:0] sel;
            d = (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 10;
            n = (m == 3) ? 2 : int'($urandom_range(1, 3));
            sel = 4'b1000 >> m;
            do_reset();
            RESETN = 1'b1;
            for (int k = 0; k < n; k++) push_word({$urandom, $urandom});
            set_modes(sel);
            wait_lanes(2 * n, 2 * n * d + 30, ok);
            step(2 * d + 5);
            checks++;
            if (!ok || obs_data.size() != 2 * n) begin failures++; $display("FAIL pace%0d_count got=%0d exp=%0d", d, obs_data.size(), 2 * n); end
            for (int i = 0; i < 2 * n; i++) begin
                checks++;
                if (lane_obs(i) !== lane_exp(i)) begin failures++; $display("FAIL pace%0d_lane%0d got=%h exp=%h", d, i, lane_obs(i), lane_exp(i)); end
            end
            for (int i = 1; i < 2 * n; i++) begin
                checks++;
                if (cyc_obs(i) - cyc_obs(i - 1) !== d) begin failures++; $display("FAIL pace%0d_gap%0d got=%0d exp=%0d", d, i, cyc_obs(i) - cyc_obs(i - 1), d); end
            end
            checks++;
            if (max_occ > 2) begin failures++; $display("FAIL pace%0d_occupancy got=%0d exp<=2", d, max_occ); end
            $display("test_pacing pace=%0d words=%0d lanes=%0d", d, n, obs_data.size());
        end
    endtask

    task automatic test_mode_change;
        bit ok;
        do_reset();
        RESETN = 1'b1;
        push_word({$urandom, $urandom});
        push_word({$urandom, $urandom});
        set_modes(4'b1001);
        wait_valid_now(20, ok);
        MODE_10G = 1'b0;
        wait_lanes(4, 80, ok);
        step(15);
        checks += 2;
        if (obs_data.size() != 4) begin failures++; $display("FAIL mchg_count got=%0d exp=4", obs_data.size()); end
        if (cyc_obs(0) - rd_first !== 3) begin failures++; $display("FAIL mchg_priority_latency got=%0d exp=3", cyc_obs(0) - rd_first); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lane_obs(i) !== lane_exp(i)) begin failures++; $display("FAIL mchg_lane%0d got=%h exp=%h", i, lane_obs(i), lane_exp(i)); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (cyc_obs(i) - cyc_obs(i - 1) !== 10) begin failures++; $display("FAIL mchg_gap%0d got=%0d exp=10", i, cyc_obs(i) - cyc_obs(i - 1)); end
        end
        $display("test_mode_change lanes=%0d", obs_data.size());
    endtask

    task automatic test_underflow;
        bit ok;
        int i1;
        int i2;
        do_reset();
        RESETN = 1'b1;
        push_word({$urandom, $urandom});
        set_modes(4'b0100);
        wait_lanes(2, 30, ok);
        step(10);
        checks += 2;
        if (obs_data.size() != 2) begin failures++; $display("FAIL uflow_count got=%0d exp=2", obs_data.size()); end
        if (cyc_obs(1) - cyc_obs(0) !== 2) begin failures++; $display("FAIL uflow_gap got=%0d exp=2", cyc_obs(1) - cyc_obs(0)); end
        i1 = int'(IDLE_TICK_CNT);
        step(10);
        i2 = int'(IDLE_TICK_CNT);
        checks++;
`ifdef LMAC_TXGB_IDLE_STATS_EN
        if (i2 - i1 !== 5) begin failures++; $display("FAIL uflow_idle_delta got=%0d exp=5", i2 - i1); end
`else
        if (i1 !== 0 || i2 !== 0) begin failures++; $display("FAIL uflow_idle_tied got=%0d/%0d exp=0", i1, i2); end
`endif
        push_word({$urandom, $urandom});
        wait_lanes(4, 40, ok);
        step(5);
        checks += 2;
        if (obs_data.size() != 4) begin failures++; $display("FAIL uflow_resume_count got=%0d exp=4", obs_data.size()); end
        if (cyc_obs(3) - cyc_obs(2) !== 2) begin failures++; $display("FAIL uflow_resume_gap got=%0d exp=2", cyc_obs(3) - cyc_obs(2)); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lane_obs(i) !== lane_exp(i)) begin failures++; $display("FAIL uflow_lane%0d got=%h exp=%h", i, lane_obs(i), lane_exp(i)); end
        end
        $display("test_underflow lanes=%0d idle=%0d->%0d", obs_data.size(), i1, i2);
    endtask

    task automatic test_no_mode;
        bit ok;
        do_reset();
        RESETN = 1'b1;
        for (int k = 0; k < 3; k++) push_word({$urandom, $urandom});
        step(20);
        checks += 3;
        if (rd_cnt !== 0) begin failures++; $display("FAIL nomode_rden got=%0d exp=0", rd_cnt); end
        if (obs_data.size() !== 0) begin failures++; $display("FAIL nomode_valid got=%0d exp=0", obs_data.size()); end
        if (TX_BUF_LEVEL !== 2'd0) begin failures++; $display("FAIL nomode_level got=%0d exp=0", TX_BUF_LEVEL); end
        set_modes(4'b0010);
        wait_valid_now(30, ok);
        set_modes(4'b0000);
        step(20);
        checks += 3;
        if (obs_data.size() !== 1) begin failures++; $display("FAIL hold_lanes got=%0d exp=1", obs_data.size()); end
        if (TX_BUF_LEVEL !== 2'd2) begin failures++; $display("FAIL hold_level got=%0d exp=2", TX_BUF_LEVEL); end
        if (rd_cnt !== 2) begin failures++; $display("FAIL hold_rden got=%0d exp=2", rd_cnt); end
        set_modes(4'b0010);
        wait_lanes(6, 60, ok);
        step(10);
        checks += 2;
        if (obs_data.size() != 6) begin failures++; $display("FAIL resume_count got=%0d exp=6", obs_data.size()); end
        if (rd_cnt !== 3) begin failures++; $display("FAIL resume_rden got=%0d exp=3", rd_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (lane_obs(i) !== lane_exp(i)) begin failures++; $display("FAIL resume_lane%0d got=%h exp=%h", i, lane_obs(i), lane_exp(i)); end
        end
        checks++;
        if (underrun_cnt !== 0) begin failures++; $display("FAIL fifo_underrun got=%0d exp=0", underrun_cnt); end
        $display("test_no_mode lanes=%0d reads=%0d", obs_data.size(), rd_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        RESETN      = 1'b0;
        MODE_10G    = 1'b0;
        MODE_5G     = 1'b0;
        MODE_2P5G   = 1'b0;
        MODE_1G     = 1'b0;
        fifo_rd_out = 64'd0;
        test_reset();
        test_stream_10g();
        test_pacing();
        test_mode_change();
        test_underflow();
        test_no_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lmac_txfifo_gearbox.md
Name: lmac_txfifo_gearbox

Overview:
Downstream consumer of the LMAC TX FIFO. It pulls 64-bit words from the FIFO read port using its read-enable and empty handshake. It splits each word into two 32-bit lanes, low half first. It emits the lanes at a rate paced by the active link-speed mode (10G/5G/2.5G/1G) toward the TX encoder.

Parameters:
- PACE_10G, 1, clocks per 32-bit lane in 10G mode
- PACE_5G, 2, clocks per lane in 5G mode
- PACE_2P5G, 4, clocks per lane in 2.5G mode
- PACE_1G, 10, clocks per lane in 1G mode
- Constraint: all PACE values 1..15; pace counter is 4 bits.

Ports:
- clk  input  1  clock, rising edge
- RESETN  input  1  asynchronous active-low reset
- MODE_10G  input  1  10G mode select
- MODE_5G  input  1  5G mode select
- MODE_2P5G  input  1  2.5G mode select
- MODE_1G  input  1  1G mode select
- TXFIFO_RD_EMPTY  input  1  FIFO has no readable word
- TXFIFO_RD_OUTPUT  input  64  FIFO read data; valid the cycle after TXFIFO_RD_EN
- TXFIFO_RD_EN  output  1  FIFO read request (combinational)
- TX_OUT_DATA  output  32  lane data (registered)
- TX_OUT_VALID  output  1  one-cycle pulse per emitted lane (registered)
- TX_BUF_LEVEL  output  2  words held in the internal buffer, 0..2
- IDLE_TICK_CNT  output  16  pace ticks with no data available (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, RESETN).
- Reset values: TX_OUT_DATA=0, TX_OUT_VALID=0, TX_BUF_LEVEL=0, half-select=low, pace counter=0, inflight=0, IDLE_TICK_CNT=0. TXFIFO_RD_EN=0 while RESETN=0.
- Mode decode: priority 10G > 5G > 2P5G > 1G. D = PACE of the selected mode. If no mode bit is set, there is no mode: no ticks, no reads, the pace counter is held at 0, and the buffer is retained.
- Pace counter: counts 0..D-1 and wraps. A tick occurs in the cycle where count == D-1. For D=1, every cycle is a tick.
- Mode change: the decoded mode is registered. When it differs from the previous cycle, the pace counter restarts at 0 that cycle. Buffered data and the half-select are preserved.
- Buffer: 2 x 64-bit entries, cur and nxt.
- Inflight: a 1-bit flag set the cycle after TXFIFO_RD_EN=1.
- Read request: TXFIFO_RD_EN = mode active & !TXFIFO_RD_EMPTY & (level + inflight − (word retiring this cycle ? 1 : 0)) < 2.
- Capture: in the cycle after TXFIFO_RD_EN, TXFIFO_RD_OUTPUT is written to the first free entry. When a retire happens in the same cycle, the ordering is compact first, then write.
- Lane emission on a tick with level > 0:
  - TX_OUT_DATA <= cur[31:0] when half=low, else cur[63:32].
  - TX_OUT_VALID <= 1.
  - half toggles.
  - After the high half is emitted, cur retires: cur <= nxt and level decrements.
- Tick with level == 0: TX_OUT_VALID <= 0 and TX_OUT_DATA holds its value.
- Non-tick cycles: TX_OUT_VALID <= 0.
- Latency: RD_EN in cycle N, capture at the end of N+1, earliest TX_OUT_VALID in cycle N+3 (at 10G).
- Throughput: in 10G mode with a non-empty FIFO, one lane per clock is sustained with no bubbles. The prefetch makes this possible.
- Simultaneous retire and capture in one cycle: level is unchanged.
- Reset mid-operation: all state clears immediately. Any FIFO word inflight is discarded, so upstream must be reset together with this block.
- The buffer never overflows; the RD_EN gating guarantees level + inflight ≤ 2.

Optional Feature:
- Macro: LMAC_TXGB_IDLE_STATS_EN.
- Defined: IDLE_TICK_CNT increments on each tick with level == 0 and saturates at 16'hFFFF. It clears only on reset.
- Undefined: IDLE_TICK_CNT is tied to 0 and the counter logic is not synthesized.

Test Plan:
- Reset: assert RESETN=0 mid-stream → all outputs 0 immediately. After release with MODE_10G=1 and FIFO empty → no RD_EN, TX_OUT_VALID stays 0.
- 10G streaming: MODE_10G=1, FIFO holds 0x1111_2222_3333_4444 then 0x5555_6666_7777_8888 → TX_OUT_VALID on 4 consecutive cycles with data 0x33334444, 0x11112222, 0x77778888, 0x55556666. First valid is 3 cycles after the first RD_EN.
- 1G pacing: MODE_1G=1, 2 words queued → 4 valid pulses exactly 10 clocks apart. TX_BUF_LEVEL never exceeds 2 and RD_EN is never asserted when level + inflight = 2.
- Mode priority and change: MODE_10G=1 and MODE_1G=1 → 10G pacing. Drop MODE_10G mid-word → counter restarts, the next lane arrives 10 clocks later, and no lane is lost or duplicated.
- Underflow: in 5G mode, the FIFO empties after 1 word → 2 lanes, then no valid. With LMAC_TXGB_IDLE_STATS_EN, IDLE_TICK_CNT increments by 1 every 2 clocks. New data resumes with the low half.
- No mode: all MODE bits 0 with FIFO non-empty → TXFIFO_RD_EN=0 and no output. Buffered words are emitted once a mode is set.
